// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - alu_op encodings produced by the instruction ALU-op decoder
//   - FSM state encoding used by alu_exec_unit
//   - is_shift(): classifies an alu_op as one of the shift operations
// Optional build macro used by the ALU files: ALU_BARREL_SHIFT_EN.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_OR   = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: purely combinational single-cycle ALU datapath.
// Ports:
//   op     in  4     alu_op encoding (unknown codes execute as ADD)
//   a      in  XLEN  operand A
//   b      in  XLEN  operand B
//   result out XLEN  single-cycle result
// Build macro ALU_BARREL_SHIFT_EN: when defined, shifts are resolved here by a
// full barrel shifter. When undefined, shift ops return operand A unchanged,
// which is the correct result for a zero shift amount; non-zero shifts are
// handled iteratively by the parent.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int SHW = $clog2(XLEN);
  logic [SHW-1:0] amt;
  assign amt = b[SHW-1:0];
`endif

  always_comb begin
    result = a + b;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:  result = a << amt;
      ALU_SRL:  result = a >> amt;
      ALU_SRA:  result = $unsigned($signed(a) >>> amt);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: result = a;
`endif
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of in-flight/held operation
//   in_valid/in_ready   input handshake
//   in_alu_op, in_a, in_b, in_tag   operation, operands, destination tag
//   out_valid/out_ready output handshake
//   out_result, out_tag result and its tag, stable while out_valid && !out_ready
// Build macro ALU_BARREL_SHIFT_EN: when defined, every op (shifts included)
// completes one cycle after accept. When undefined, non-zero shifts iterate
// one bit per cycle through the SHIFT state.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(XLEN);

  state_t           state_reg, state_next;
  logic [XLEN-1:0]  result_reg, result_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic [XLEN-1:0]  acc_reg, acc_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic [3:0]       op_reg, op_next;

  logic [XLEN-1:0]  core_result;
  logic [XLEN-1:0]  acc_shifted;
  logic [SHW-1:0]   amt;
  logic             accept;

  assign amt = in_b[SHW-1:0];

  alu_comb_core #(.XLEN(XLEN)) u_core (
    .op     (in_alu_op),
    .a      (in_a),
    .b      (in_b),
    .result (core_result)
  );

  // One-bit step of the iterative shifter; op_reg only ever holds a shift op.
  always_comb begin
    acc_shifted = {acc_reg[XLEN-1], acc_reg[XLEN-1:1]};
    case (op_reg)
      ALU_SLL: acc_shifted = {acc_reg[XLEN-2:0], 1'b0};
      ALU_SRL: acc_shifted = {1'b0, acc_reg[XLEN-1:1]};
      default: acc_shifted = {acc_reg[XLEN-1], acc_reg[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    tag_next    = tag_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;

    // DONE with out_ready frees the slot in the same cycle (no bubble).
    in_ready = !flush && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
    accept   = in_valid && in_ready;

    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            tag_next = in_tag;
`ifndef ALU_BARREL_SHIFT_EN
            if (is_shift(in_alu_op) && (amt != '0)) begin
              acc_next   = in_a;
              cnt_next   = amt;
              op_next    = in_alu_op;
              state_next = SHIFT;
            end else
`endif
            begin
              result_next = core_result;
              state_next  = DONE;
            end
          end else if ((state_reg == DONE) && out_ready) begin
            state_next = IDLE;
          end
        end
        SHIFT: begin
          acc_next = acc_shifted;
          cnt_next = cnt_reg - SHW'(1);
          if (cnt_reg == SHW'(1)) begin
            result_next = acc_shifted;
            state_next  = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      tag_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      op_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      tag_reg    <= tag_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
    end
  end

  assign out_valid  = (state_reg == DONE);
  assign out_result = result_reg;
  assign out_tag    = tag_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: self-checking bench for alu_exec_unit (XLEN=32, TAG_W=5).
// Inputs change 2 time units after a rising edge; outputs are sampled on the
// falling edge. Accepted operations push their expected {tag,result} onto a
// queue; a monitor pops and compares whenever a result is handed off.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  alu_exec_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_op  (in_alu_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got tag %h result %h expected none", out_tag, out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn tag=%0d result=%h expected=%h", out_tag, out_result, e.res);
        chk("out_result", out_result, e.res);
        chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
      end
    end
  end

  // Called in the post-edge phase; returns in the post-edge phase of the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    int k;
    in_alu_op = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    in_valid  = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end else begin
      exp_q.push_back({tag, exp});
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_a     = $urandom();
    in_b     = $urandom();
  endtask

  task automatic measure(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input int lat,
                         input string name);
    int n;
    int busy_bad;
    issue(op, a, b, tag, exp);
    n = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && in_ready) busy_bad++;
    end while (!out_valid && n < 100);
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_in_ready_busy"}, 32'(busy_bad), 32'd0);
    @(posedge clk);
    #2;
  endtask

  vec_t vecs[16];

  initial begin
    int n;
    vecs[0]  = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[4]  = '{4'b1111,  32'h0000_0003, 32'h0000_0004, 32'h0000_0007};
    vecs[5]  = '{4'b0010,  32'h0000_0005, 32'h0000_0006, 32'h0000_000B};
    vecs[6]  = '{ALU_SLT,  32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0000};
    vecs[7]  = '{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[8]  = '{ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    vecs[9]  = '{ALU_OR,   32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF};
    vecs[10] = '{ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    vecs[11] = '{ALU_SLL,  32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010};
    vecs[12] = '{ALU_SRL,  32'h8000_0000, 32'h0000_0008, 32'h0080_0000};
    vecs[13] = '{ALU_SRA,  32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF};
    vecs[14] = '{ALU_SRA,  32'h4000_0000, 32'h0000_0004, 32'h0400_0000};
    vecs[15] = '{ALU_SLL,  32'h0000_1234, 32'h0000_0020, 32'h0000_1234};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_alu_op = 4'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_tag    = 5'd0;
    out_ready = 1'b1;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_out_tag", {27'd0, out_tag}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Table of vectors, issued back to back with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);
    end

    // Latency checks.
    measure(ALU_ADD, 32'd10, 32'd20, 5'd20, 32'd30, 1, "add");
    measure(ALU_SRA, 32'h8000_0000, 32'h0000_003F, 5'd21, 32'hFFFF_FFFF,
            BARREL ? 1 : 32, "sra31");
    measure(ALU_SRL, 32'hF000_0000, 32'h0000_0003, 5'd22, 32'h1E00_0000,
            BARREL ? 1 : 4, "srl3");

    // Backpressure: XOR result held for 5 cycles.
    out_ready = 1'b0;
    issue(ALU_XOR, 32'h1234_5678, 32'hFFFF_0000, 5'd7, 32'hEDCB_5678);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_result", out_result, 32'hEDCB_5678);
      chk("hold_out_tag", {27'd0, out_tag}, 32'd7);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    in_alu_op = ALU_AND;
    in_a      = 32'h0000_F0F0;
    in_b      = 32'h0000_FF00;
    in_tag    = 5'd9;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back({5'd9, 32'h0000_F000});
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_no_bubble", {31'd0, out_valid}, 32'd1);
    chk("b2b_result", out_result, 32'h0000_F000);
    @(posedge clk);
    #2;

    // Flush on the third shift cycle of SLL by 10.
    issue(ALU_SLL, 32'h0000_0001, 32'h0000_000A, 5'd3, 32'h0000_0400);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #2;
    flush = 1'b0;
    if (!BARREL) void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("flush_no_output", 32'(n), 32'd0);

    // Flush coinciding with an offered op: not accepted.
    @(posedge clk);
    #2;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_alu_op = ALU_ADD;
    in_a      = 32'd1;
    in_b      = 32'd1;
    in_tag    = 5'd11;
    @(negedge clk);
    chk("flush_block_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #2;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_block_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #2;

    // Asynchronous reset in the middle of a shift.
    issue(ALU_SLL, 32'h0000_0001, 32'h0000_0014, 5'd4, 32'h0010_0000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    if (!BARREL) void'(exp_q.pop_back());
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_result", out_result, 32'd0);
    chk("arst_out_tag", {27'd0, out_tag}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    measure(ALU_SLL, 32'h0000_1234, 32'h0000_0020, 5'd5, 32'h0000_1234, 1, "sll0_after_reset");

    // Drain and make sure every expectation was matched.
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit alu_op produced by the instruction ALU-op decoder, together with two register/immediate operands.
- Single-cycle for arithmetic, logic and compare ops; shifts run iteratively, 1 bit per cycle, unless the barrel-shift option is compiled in.
- Valid/ready handshake on both sides. Sits between decode/operand-select and writeback.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- TAG_W, 5, width of the destination-register tag carried alongside the result.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of any in-flight or held operation.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept this cycle.
- in_alu_op  input  4  decoder encoding (see Behaviour).
- in_a  input  XLEN  operand A (rs1).
- in_b  input  XLEN  operand B (rs2 or immediate).
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts.
- out_result  output  XLEN  result.
- out_tag  output  TAG_W  tag of result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n is low, state=IDLE, out_valid=0, out_result=0, out_tag=0, internal counter=0. Asserting rst_n mid-shift aborts the operation; no result is produced.
- alu_op encoding:
  - 0000 ADD, 0001 SUB
  - 0100 SLL, 0110 SRL, 0111 SRA
  - 1001 AND, 1010 OR, 1011 XOR
  - 1100 SLTU, 1101 SLT
  - Any other code is executed as ADD, matching the decoder default.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. SLT is signed compare, SLTU unsigned; result is 1 or 0, zero-extended.
- Shift amount: in_b[$clog2(XLEN)-1:0]; upper bits of in_b are ignored. SRA replicates bit XLEN-1.
- States:
  - IDLE: in_ready=1.
    - Accept (in_valid & in_ready & !flush), non-shift op: compute, register result/tag, go to DONE.
    - Accept, shift op with amount 0: result=in_a, go to DONE.
    - Accept, shift op with amount s>0: load acc=in_a, cnt=s, latch op/tag, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, acc is shifted 1 bit in the latched direction/type and cnt is decremented. The cycle cnt goes 1→0 moves to DONE with out_result=shifted acc.
  - DONE: out_valid=1; result and tag are stable until the handshake.
    - out_ready=1: in_ready=1 the same cycle, so back-to-back issue is allowed. A new op accepted in that cycle follows the IDLE accept rules; otherwise go to IDLE.
    - out_ready=0: hold; in_ready=0.
- Latency, accept cycle N:
  - Non-shift op or zero shift: out_valid at N+1.
  - Serial shift of s: out_valid at N+1+s, so SLL by 31 = 32 cycles.
- flush: highest priority. Next state is IDLE, out_valid=0 next cycle, and any input offered that cycle is not accepted (in_ready forced 0 while flush=1). Flush during SHIFT discards acc.
- Simultaneous out handshake and in accept in DONE: the new result replaces the old on the same edge, with no bubble.
- in_* may change freely while not accepted; only the accept cycle is sampled.

Optional Feature:
- ALU_BARREL_SHIFT_EN
- Defined: the SHIFT state is omitted and shifts resolve combinationally in the accept cycle with a full barrel shifter. All ops then have latency 1.
- Undefined: iterative 1-bit/cycle shifter as above, with smaller area. Results are bit-identical in both builds; only latency differs.

Decomposition:
- Shared package alu_pkg:
  - alu_op localparams (ALU_ADD=4'b0000, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_AND, ALU_OR, ALU_XOR, ALU_SLTU, ALU_SLT), shared with the decoder.
  - State encoding constants: IDLE, SHIFT, DONE.
- One sub-module: alu_comb_core, which is purely combinational. It takes op/a/b and produces the single-cycle result, and includes the barrel shifter when ALU_BARREL_SHIFT_EN is defined. alu_exec_unit owns the FSM, counter, shift register and handshake.

Test Plan:
1. ADD 0x7FFFFFFF + 0x1, out_ready=1 -> out_valid the next cycle, result 0x80000000. SUB 0x0 - 0x1 -> 0xFFFFFFFF.
2. SLT a=0xFFFFFFFF, b=0x1 -> 1. SLTU with same operands -> 0. Illegal op 4'b1111, a=3, b=4 -> 7.
3. SRA a=0x80000000, b=0x3F (amount 31) -> 0xFFFFFFFF. Serial build: out_valid exactly 32 cycles after accept, in_ready=0 throughout. Barrel build: 1 cycle.
4. Backpressure: XOR result held with out_ready=0 for 5 cycles -> out_result/out_tag stable, in_ready=0. Raise out_ready with in_valid=1 (AND 0xF0F0&0xFF00) -> second result 0xF000 on the next cycle, no bubble.
5. Flush on cycle 3 of an SLL by 10 -> out_valid never asserts for that op, in_ready=1 the cycle after flush. Flush coinciding with in_valid -> op not accepted.
6. Deassert rst_n mid-shift asynchronously (between clock edges) -> out_valid=0 and out_result=0 immediately. After release, a shift of 0 (SLL a=0x1234, b=0x20) -> result 0x1234, latency 1.
